// File: rtl/regfile_write_queue.sv
// Writeback write queue in front of the register file write port, with youngest-wins bypass lookups.
// Optional macro WBQ_COALESCE_EN: a write to the youngest entry's address overwrites that entry.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int AW    = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     wr_stall,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  input  logic [AW-1:0]            byp_addr1,
  output logic                     byp_hit1,
  output logic [DW-1:0]            byp_data1,
  input  logic [AW-1:0]            byp_addr2,
  output logic                     byp_hit2,
  output logic [DW-1:0]            byp_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic          empty, full, drain_fire, coalesce, accept, alloc;
  logic [PW-1:0] youngest, wr_idx;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign youngest = tail_q - PW'(1);

  assign wr_en      = ~empty;
  assign wr_addr    = empty ? '0 : addr_q[head_q];
  assign wr_data    = empty ? '0 : data_q[head_q];
  assign drain_fire = wr_en & ~wr_stall;

`ifdef WBQ_COALESCE_EN
  // Merging into the head while it is being written would lose the new data, so allocate instead.
  assign coalesce = ~empty & (in_addr != '0) & (in_addr == addr_q[youngest])
                  & ~((count_q == CW'(1)) & drain_fire);
`else
  assign coalesce = 1'b0;
`endif

  assign in_ready = ~full | drain_fire | coalesce;
  // Writes to the hardwired zero register complete the handshake but are dropped.
  assign accept   = in_valid & in_ready & (in_addr != '0);
  assign alloc    = accept & ~coalesce;
  assign wr_idx   = coalesce ? youngest : tail_q;
  assign count    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (drain_fire) head_d = head_q + PW'(1);
      if (alloc)      tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(alloc) - CW'(drain_fire);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage has no reset; count alone decides validity, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (accept && !flush) begin
      addr_q[wr_idx] <= in_addr;
      data_q[wr_idx] <= in_data;
    end
  end

  // Walk entries oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if ((byp_addr1 != '0) && (addr_q[head_q + PW'(i)] == byp_addr1)) begin
          byp_hit1  = 1'b1;
          byp_data1 = data_q[head_q + PW'(i)];
        end
        if ((byp_addr2 != '0) && (addr_q[head_q + PW'(i)] == byp_addr2)) begin
          byp_hit2  = 1'b1;
          byp_data2 = data_q[head_q + PW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue; expectations follow WBQ_COALESCE_EN when defined.
module tb_regfile_write_queue;

  logic       CLK, RST_N, flush, in_valid, in_ready, wr_stall, wr_en;
  logic [3:0] in_addr, wr_addr, byp_addr1, byp_addr2;
  logic [7:0] in_data, wr_data, byp_data1, byp_data2;
  logic       byp_hit1, byp_hit2;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  regfile_write_queue #(.DEPTH(4), .DW(8), .AW(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .byp_addr1(byp_addr1), .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_addr2(byp_addr2), .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    wr_stall = 1'b0; byp_addr1 = '0; byp_addr2 = '0;
    #12;
    check("rst_count", count, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_byp_hit1", byp_hit1, 0);
    RST_N = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    step();

    // Single write: visible the cycle after enqueue, gone the cycle after that.
    byp_addr1 = 4'h3;
    push(4'h3, 8'hA5);
    #1;
    check("lat_wr_en", wr_en, 1);
    check("lat_wr_addr", wr_addr, 3);
    check("lat_wr_data", wr_data, 8'hA5);
    check("lat_count", count, 1);
    check("lat_byp_drain_hit", byp_hit1, 1);
    check("lat_byp_drain_data", byp_data1, 8'hA5);
    step();
    check("lat_empty_count", count, 0);
    check("lat_empty_wr_en", wr_en, 0);
    check("lat_empty_wr_data", wr_data, 0);
    check("lat_empty_byp_hit", byp_hit1, 0);

    // Fill while stalled, then drain in order.
    wr_stall = 1'b1;
    push(4'h2, 8'h11);
    push(4'h3, 8'h22);
    push(4'h4, 8'h33);
    push(4'h5, 8'h44);
    in_valid = 1'b1; in_addr = 4'h6; in_data = 8'h55;
    #1;
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    check("full_stall_wr_data", wr_data, 8'h11);
    in_valid = 1'b0;
    wr_stall = 1'b0;
    #1;
    check("drain0_addr", wr_addr, 2);
    check("drain0_data", wr_data, 8'h11);
    step();
    check("drain1_data", wr_data, 8'h22);
    step();
    check("drain2_data", wr_data, 8'h33);
    step();
    check("drain3_addr", wr_addr, 5);
    check("drain3_data", wr_data, 8'h44);
    step();
    check("drain_done_count", count, 0);

    // Bypass: youngest of two same-address entries wins; address 0 never hits.
    wr_stall = 1'b1;
    push(4'h9, 8'h10);
    push(4'h9, 8'h20);
    byp_addr1 = 4'h9; byp_addr2 = 4'h0;
    in_valid = 1'b1; in_addr = 4'h9; in_data = 8'h30;
    #1;
    check("byp1_hit", byp_hit1, 1);
    check("byp1_youngest", byp_data1, 8'h20);
    check("byp2_zero_hit", byp_hit2, 0);
    check("byp2_zero_data", byp_data2, 0);
    in_valid = 1'b0;
    byp_addr2 = 4'h5;
    #1;
    check("byp2_miss_hit", byp_hit2, 0);
    check("byp2_miss_data", byp_data2, 0);
    push(4'hA, 8'h66);
    byp_addr2 = 4'h9;
    #1;
    check("byp2_older_over_new", byp_data2, 8'h20);
`ifdef WBQ_COALESCE_EN
    check("pre_flush_count", count, 2);
`else
    check("pre_flush_count", count, 3);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_wr_en", wr_en, 0);
    check("flush_byp_hit", byp_hit1, 0);
    wr_stall = 1'b0;
    step();
    check("flush_quiet_wr_en", wr_en, 0);

    // Zero-register write: handshake completes, nothing stored.
    in_valid = 1'b1; in_addr = 4'h0; in_data = 8'hFF;
    #1;
    check("zero_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("zero_count", count, 0);
    check("zero_wr_en", wr_en, 0);

    // Full queue streaming with simultaneous enqueue/drain; 12 writes wrap the pointers.
    wr_stall = 1'b1;
    for (int k = 0; k < 4; k++) push(4'((k % 7) + 1), 8'(8'h80 + k));
    wr_stall = 1'b0;
    for (int k = 4; k < 12; k++) begin
      in_valid = 1'b1; in_addr = 4'((k % 7) + 1); in_data = 8'(8'h80 + k);
      #1;
      check("stream_in_ready", in_ready, 1);
      check("stream_count", count, 4);
      check("stream_wr_data", wr_data, 8'(8'h80 + k - 4));
      check("stream_wr_addr", wr_addr, 4'(((k - 4) % 7) + 1));
      step();
    end
    in_valid = 1'b0;
    for (int k = 8; k < 12; k++) begin
      #1;
      check("tail_wr_data", wr_data, 8'(8'h80 + k));
      step();
    end
    check("stream_done_count", count, 0);

    // Back-to-back writes through an otherwise empty queue: count holds at 1.
    push(4'h1, 8'hC1);
    in_valid = 1'b1; in_addr = 4'h2; in_data = 8'hC2;
    #1;
    check("one_deep_count", count, 1);
    check("one_deep_wr_data", wr_data, 8'hC1);
    step();
    in_valid = 1'b0;
    check("one_deep_next", wr_data, 8'hC2);
    step();
    check("one_deep_done", count, 0);

    // Same-address sequence: merges under coalescing, separate slots otherwise.
    wr_stall = 1'b1;
    push(4'h6, 8'h01);
    push(4'h7, 8'h02);
    push(4'h7, 8'h03);
`ifdef WBQ_COALESCE_EN
    check("coal_count", count, 2);
`else
    check("coal_count", count, 3);
`endif
    wr_stall = 1'b0;
    #1;
    check("coal_d0_addr", wr_addr, 6);
    check("coal_d0_data", wr_data, 8'h01);
    step();
    check("coal_d1_addr", wr_addr, 7);
`ifdef WBQ_COALESCE_EN
    check("coal_d1_data", wr_data, 8'h03);
`else
    check("coal_d1_data", wr_data, 8'h02);
    step();
    check("coal_d2_data", wr_data, 8'h03);
`endif
    step();
    check("coal_done_count", count, 0);

    // Reset mid-operation discards pending writes immediately.
    wr_stall = 1'b1;
    push(4'h4, 8'hD4);
    push(4'h5, 8'hD5);
    #2;
    RST_N = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_wr_en", wr_en, 0);
    RST_N = 1'b1;
    wr_stall = 1'b0;
    step();
    check("midrst_quiet", wr_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Writeback-side write queue in front of the register file's write port.
- Accepts resolved register writes (full 4-bit address plus 8-bit data) from the mem/writeback stage over a valid/ready handshake.
- Buffers up to DEPTH writes and drains one per cycle into the register file's write_reg/write_reg_full/data_in inputs, which are driven as a full-address write.
- Provides two bypass lookup ports so decode-stage reads see pending (not yet written) values, youngest entry wins.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..8.
- DW, 8, data width.
- AW, 4, full register address width (bank bit plus 3-bit index).

Ports:
- CLK  input  1  clock, all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all pending entries.
- in_valid  input  1  write request valid.
- in_ready  output  1  queue can accept this cycle.
- in_addr  input  AW  full destination register address.
- in_data  input  DW  write data.
- wr_stall  input  1  register file cannot take a write this cycle.
- wr_en  output  1  drives the register file's write_reg; full_addr is tied high.
- wr_addr  output  AW  drives write_reg_full.
- wr_data  output  DW  drives data_in.
- byp_addr1  input  AW  lookup address, read port 1.
- byp_hit1  output  1  a pending entry matches byp_addr1.
- byp_data1  output  DW  data of the youngest matching entry, 0 when no hit.
- byp_addr2  input  AW  lookup address, read port 2.
- byp_hit2  output  1  a pending entry matches byp_addr2.
- byp_data2  output  DW  data of the youngest matching entry, 0 when no hit.
- count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage is a circular buffer with head (oldest) pointer, tail pointer and a count register.
- Reset, asynchronous on RST_N low:
  - head = tail = count = 0; entry contents are don't-care.
  - wr_en = 0, wr_addr = 0, wr_data = 0; byp_hit* = 0, byp_data* = 0.
  - in_ready = 1 when RST_N is deasserted.
- Enqueue:
  - Occurs on the edge where in_valid & in_ready.
  - in_ready = (count < DEPTH) | (count == DEPTH & drain_fire), where drain_fire = wr_en & ~wr_stall.
  - in_addr == 0 (hardwired zero register): the request is accepted (handshake completes) but not stored.
- Drain:
  - wr_en = (count != 0); wr_addr and wr_data are taken combinationally from the head entry.
  - With wr_en = 0, wr_addr and wr_data are 0.
  - On drain_fire the head advances and count decrements.
  - Latency: an entry enqueued at edge N is on wr_* during cycle N+1 and written at edge N+1 when the queue was empty and wr_stall = 0.
- Simultaneous enqueue and drain: count is unchanged and both pointers advance; legal when full and when count == 1.
- Pointer wrap: pointers wrap modulo DEPTH; full and empty are distinguished only by count.
- Bypass:
  - Purely combinational; compares the byp address against all valid entries.
  - The youngest match (closest to tail) supplies the data.
  - byp_addr == 0 never hits.
  - The entry currently being drained still counts as pending this cycle.
  - An incoming in_data in the same cycle is NOT bypassed.
- flush:
  - Sets head = tail = count = 0 at the edge.
  - Takes precedence over enqueue and drain in the same cycle.
  - The head write presented during the flush cycle still occurs if wr_stall = 0, because the register file samples it on the same edge.
- Reset mid-operation: pending writes are discarded and are never issued.
- Ordering: drain order equals accept order; multiple entries to the same address are allowed (unless coalescing is enabled).

Optional Feature:
- Macro: WBQ_COALESCE_EN.
- Defined:
  - An accepted write whose in_addr equals the youngest valid entry's address overwrites that entry's data instead of allocating a new slot; count is unchanged.
  - Coalescing is suppressed when that youngest entry is the head and drain_fire is 1 in the same cycle; a normal enqueue happens instead.
  - in_ready is also 1 when full and coalescing applies.
- Undefined: every accepted nonzero write allocates a slot.

Test Plan:
- Reset, then enqueue addr 4'h3 data 8'hA5 with wr_stall = 0 → next cycle wr_en = 1, wr_addr = 3, wr_data = A5; cycle after that count = 0 and wr_en = 0.
- wr_stall = 1 and enqueue 4 writes (addr 2,3,4,5, data 11,22,33,44) → count = 4, in_ready = 0; release wr_stall → writes drain in order 11,22,33,44 on consecutive cycles.
- Pending entries addr 9 = 8'h10 then addr 9 = 8'h20, byp_addr1 = 9 → byp_hit1 = 1, byp_data1 = 20; byp_addr2 = 0 → byp_hit2 = 0.
- Full queue with wr_stall = 0 and in_valid = 1 → in_ready = 1, count stays 4; pointers wrap across 12 consecutive writes with no data loss.
- Enqueue addr 0 data FF → handshake completes, count stays 0, wr_en stays 0; flush with 3 entries pending → count = 0 next cycle and no further writes.
- WBQ_COALESCE_EN, wr_stall = 1, enqueue addr 6 = 01, then addr 7 = 02, then addr 7 = 03 → count = 2; drain gives 6 = 01, then 7 = 03.
